// File: rtl/mat_line_fetcher_if.sv
// mat_line_fetcher_if
//   Avalon-MM style read-only bus between the line fetcher (master) and the
//   line memory (slave). One read may be outstanding at a time.
//
//   address       master -> slave  32      word address of the requested line
//   read          master -> slave  1       read request, held until accepted
//   readdata      slave -> master  LINE_W  returned line
//   readdatavalid slave -> master  1       qualifies readdata
//   waitrequest   slave -> master  1       stall; request accepted when read=1 and waitrequest=0
interface mat_line_fetcher_if #(
  parameter int LINE_W = 64
) ();
  logic [31:0]       address;
  logic              read;
  logic [LINE_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address,
    output read,
    input  readdata,
    input  readdatavalid,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  read,
    output readdata,
    output readdatavalid,
    output waitrequest
  );
endinterface

// File: rtl/mat_line_fetcher.sv
// mat_line_fetcher
//   Read master feeding mat_vec_mult. A start pulse clears the MAC array and
//   then fetches DEPTH matrix lines followed by one vector line. Each returned
//   line is registered and presented on line_out with a one-cycle a_wren
//   (matrix line) or b_wren (vector line). Waitrequest stalls and arbitrary
//   read latency are tolerated; a missing response raises a sticky err.
//
//   clk       in   1       rising-edge clock
//   rst_n     in   1       synchronous active-low reset
//   start     in   1       begin a sequence (honoured only in IDLE or DONE)
//   bus       master modport of mat_line_fetcher_if (address/read/readdata/
//             readdatavalid/waitrequest)
//   clr       out  1       one-cycle MAC clear
//   a_wren    out  1       matrix line write strobe
//   b_wren    out  1       vector line write strobe
//   line_out  out  LINE_W  registered line, byte i drives lane i
//   line_idx  out  4       index of the line being requested or written
//   busy      out  1       sequence in progress
//   done      out  1       sequence finished (successfully or by timeout)
//   err       out  1       sticky timeout flag
//
//   Every output is either a register or a decode of the state register, so
//   no input reaches an output combinationally.
module mat_line_fetcher #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int BASE_ADDR  = 0,
  parameter int TIMEOUT    = 255,
  parameter int LINE_W     = DATA_WIDTH * DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mat_line_fetcher_if.master  bus,
  output logic                clr,
  output logic                a_wren,
  output logic                b_wren,
  output logic [LINE_W-1:0]   line_out,
  output logic [3:0]          line_idx,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int          CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]  LAST_IDX = 4'(DEPTH);
  localparam logic [31:0] BASE32   = 32'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    REQ       = 3'd2,
    WAIT_DATA = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [LINE_W-1:0] line_q,  line_d;
  logic              err_q,   err_d;

  // ---- state and datapath registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  // ---- next-state and register updates ----
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end

      CLEAR: begin
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = REQ;
      end

      // readdatavalid is deliberately not looked at here: with only one read
      // outstanding, anything arriving now is a leftover and must be dropped.
      REQ: begin
        if (!bus.waitrequest) begin
          cnt_d   = '0;
          state_d = WAIT_DATA;
        end
      end

      // The counter counts response-less cycles; after TIMEOUT of them the
      // sequence is abandoned without issuing a strobe.
      WAIT_DATA: begin
        if (bus.readdatavalid) begin
          line_d  = bus.readdata;
          state_d = WRITE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = cnt_q + CNT_W'(1);
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      // idx stays at DEPTH after the vector line so line_idx keeps pointing
      // at the last line written while in DONE.
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = REQ;
        end
      end

      DONE: begin
        if (start) state_d = CLEAR;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    clr    = (state_q == CLEAR);
    a_wren = (state_q == WRITE) && (idx_q != LAST_IDX);
    b_wren = (state_q == WRITE) && (idx_q == LAST_IDX);
    busy   = (state_q != IDLE) && (state_q != DONE);
    done   = (state_q == DONE);
  end

  // The address is only driven during a request so the bus idles at zero.
  assign bus.read    = (state_q == REQ);
  assign bus.address = (state_q == REQ) ? (BASE32 + {28'd0, idx_q}) : 32'd0;
  assign line_out    = line_q;
  assign line_idx    = idx_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mat_line_fetcher.sv
module tb_mat_line_fetcher;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;
  localparam int BASE_ADDR  = 16;
  localparam int TIMEOUT    = 255;
  localparam int LINE_W     = DATA_WIDTH * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              clr, a_wren, b_wren, busy, done, err;
  logic [LINE_W-1:0] line_out;
  logic [3:0]        line_idx;

  mat_line_fetcher_if #(.LINE_W(LINE_W)) bus ();

  mat_line_fetcher #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .clr     (clr),
    .a_wren  (a_wren),
    .b_wren  (b_wren),
    .line_out(line_out),
    .line_idx(line_idx),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_line(input int k);
    logic [7:0] b;
    b = 8'(k + 1);
    if (k < DEPTH) return {8{b}};
    return 64'h0807060504030201;
  endfunction

  // ---------------- memory model ----------------
  int         wait_n = 0;
  int         lat_n  = 1;
  int         drop_k = -1;
  bit         spur   = 1'b0;
  int         stall_left = 0;
  bit         in_req  = 1'b0;
  bit         pending = 1'b0;
  int         lat_left = 0;
  logic [63:0] pend_data = '0;
  logic [31:0] stall_addr = '0;

  initial begin
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
  end

  always @(negedge clk) begin
    int k;
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
    bus.waitrequest   = 1'b0;
    if (pending) begin
      lat_left--;
      if (lat_left <= 0) begin
        pending           = 1'b0;
        bus.readdatavalid = 1'b1;
        bus.readdata      = pend_data;
      end
    end
    if (!bus.read && in_req) begin
      chk("read_dropped_in_stall", 64'(bus.read), 64'd1);
      in_req = 1'b0;
    end
    if (bus.read) begin
      if (!in_req) begin
        in_req     = 1'b1;
        stall_left = wait_n;
        stall_addr = bus.address;
      end else begin
        chk("stall_addr", 64'(bus.address), 64'(stall_addr));
      end
      if (spur) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = 64'hDEAD_BEEF_0BAD_F00D;
      end
      if (stall_left > 0) begin
        bus.waitrequest = 1'b1;
        stall_left--;
      end else begin
        in_req = 1'b0;
        k = int'(bus.address) - BASE_ADDR;
        if (k != drop_k) begin
          pending   = 1'b1;
          lat_left  = lat_n;
          pend_data = exp_line(k);
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    bit          is_b;
    logic [63:0] line;
    int          idx;
  } exp_t;

  exp_t        q[$];
  int          ncnt = 0, start_n = 0;
  int          a_cnt, b_cnt, clr_cnt, clr_rel, b_rel, done_rel, err_rel;
  bit          tmode = 1'b0;
  bit          prev_done = 1'b0, prev_err = 1'b0;
  logic [63:0] last_line = '0;

  always @(negedge clk) begin
    exp_t e;
    ncnt++;
    if (clr) begin
      clr_cnt++;
      clr_rel = ncnt - start_n;
    end
    if (a_wren || b_wren) begin
      if (a_wren) a_cnt++;
      if (b_wren) begin
        b_cnt++;
        b_rel = ncnt - start_n;
      end
      if (q.size() == 0) begin
        chk("extra_strobe", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", {62'd0, a_wren, b_wren}, e.is_b ? 64'd1 : 64'd2);
        chk("line_out", line_out, e.line);
        chk("line_idx", 64'(line_idx), 64'(e.idx));
        last_line = e.line;
        if (tmode) chk("strobe_cycle", 64'(ncnt - start_n), 64'(4 + 3 * e.idx));
      end
    end
    if (spur && bus.read) chk("spur_line_hold", line_out, last_line);
    if (done && !prev_done) done_rel = ncnt - start_n;
    if (err && !prev_err) err_rel = ncnt - start_n;
    prev_done = done;
    prev_err  = err;
  end

  // ---------------- helpers ----------------
  task automatic clear_stats();
    a_cnt = 0; b_cnt = 0; clr_cnt = 0;
    clr_rel = -1; b_rel = -1; done_rel = -1; err_rel = -1;
  endtask

  task automatic push_all();
    exp_t e;
    for (int k = 0; k <= DEPTH; k++) begin
      e.is_b = (k == DEPTH);
      e.line = exp_line(k);
      e.idx  = k;
      q.push_back(e);
    end
  endtask

  task automatic do_start();
    @(negedge clk); #1;
    start   = 1'b1;
    start_n = ncnt;
    @(negedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int i;
    i = 0;
    while (!done && i < maxc) begin
      @(negedge clk); #1;
      i++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_clr"},      64'(clr), 64'd0);
    chk({tag, "_a_wren"},   64'(a_wren), 64'd0);
    chk({tag, "_b_wren"},   64'(b_wren), 64'd0);
    chk({tag, "_read"},     64'(bus.read), 64'd0);
    chk({tag, "_address"},  64'(bus.address), 64'd0);
    chk({tag, "_line_out"}, line_out, 64'd0);
    chk({tag, "_line_idx"}, 64'(line_idx), 64'd0);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_done"},     64'(done), 64'd0);
    chk({tag, "_err"},      64'(err), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int i;
    rst_n = 1'b0;
    start = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // nominal: zero wait, latency 1, exact cycle positions
    clear_stats();
    push_all();
    tmode = 1'b1;
    do_start();
    wait_done("nom_done", 100);
    tmode = 1'b0;
    chk("nom_clr_cycle", 64'(clr_rel), 64'd1);
    chk("nom_clr_count", 64'(clr_cnt), 64'd1);
    chk("nom_b_cycle",   64'(b_rel), 64'd28);
    chk("nom_done_cycle", 64'(done_rel), 64'd29);
    chk("nom_a_count",   64'(a_cnt), 64'd8);
    chk("nom_b_count",   64'(b_cnt), 64'd1);
    chk("nom_err",       64'(err), 64'd0);
    chk("nom_left",      64'(q.size()), 64'd0);

    // stalls: 3 wait cycles per request, latency 4; restarted from DONE
    wait_n = 3; lat_n = 4;
    clear_stats();
    push_all();
    do_start();
    wait_done("stall_done", 400);
    chk("stall_clr_cycle", 64'(clr_rel), 64'd1);
    chk("stall_a_count",   64'(a_cnt), 64'd8);
    chk("stall_b_count",   64'(b_cnt), 64'd1);
    chk("stall_err",       64'(err), 64'd0);
    chk("stall_left",      64'(q.size()), 64'd0);

    // start pulses in REQ and in WRITE must be ignored
    wait_n = 0; lat_n = 1;
    clear_stats();
    push_all();
    do_start();
    @(negedge clk); #1;
    chk("busy_in_req", 64'(bus.read), 64'd1);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    i = 0;
    while (!a_wren && i < 20) begin
      @(negedge clk); #1;
      i++;
    end
    chk("busy_in_write", 64'(a_wren), 64'd1);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done("busy_done", 100);
    chk("busy_clr_count",  64'(clr_cnt), 64'd1);
    chk("busy_a_count",    64'(a_cnt), 64'd8);
    chk("busy_b_count",    64'(b_cnt), 64'd1);
    chk("busy_b_cycle",    64'(b_rel), 64'd28);
    chk("busy_done_cycle", 64'(done_rel), 64'd29);
    chk("busy_left",       64'(q.size()), 64'd0);

    // spurious readdatavalid during every REQ cycle
    wait_n = 1;
    spur = 1'b1;
    clear_stats();
    push_all();
    do_start();
    wait_done("spur_done", 200);
    spur = 1'b0;
    wait_n = 0;
    chk("spur_a_count", 64'(a_cnt), 64'd8);
    chk("spur_b_count", 64'(b_cnt), 64'd1);
    chk("spur_err",     64'(err), 64'd0);
    chk("spur_left",    64'(q.size()), 64'd0);

    // timeout on line 5
    drop_k = 5;
    clear_stats();
    push_all();
    do_start();
    wait_done("to_done", 2000);
    chk("to_err",       64'(err), 64'd1);
    chk("to_err_with_done", 64'(err_rel), 64'(done_rel));
    chk("to_a_count",   64'(a_cnt), 64'd5);
    chk("to_b_count",   64'(b_cnt), 64'd0);
    chk("to_left",      64'(q.size()), 64'd4);
    q.delete();
    drop_k = -1;

    // a later start clears err and completes normally
    clear_stats();
    push_all();
    do_start();
    @(negedge clk); #1;
    chk("re_err_cleared", 64'(err), 64'd0);
    wait_done("re_done", 100);
    chk("re_err",     64'(err), 64'd0);
    chk("re_a_count", 64'(a_cnt), 64'd8);
    chk("re_b_count", 64'(b_cnt), 64'd1);
    chk("re_left",    64'(q.size()), 64'd0);

    // reset during line 3 WAIT_DATA, stale response arrives afterwards
    lat_n = 4;
    clear_stats();
    push_all();
    do_start();
    i = 0;
    while (!(bus.read && !bus.waitrequest && bus.address == 32'(BASE_ADDR + 3)) && i < 100) begin
      @(negedge clk); #1;
      i++;
    end
    chk("mid_line3_req", 64'(bus.address), 64'(BASE_ADDR + 3));
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check_zero("mid_rst");
    repeat (8) @(negedge clk);
    #1;
    check_zero("mid_after");
    chk("mid_a_count", 64'(a_cnt), 64'd3);
    chk("mid_b_count", 64'(b_cnt), 64'd0);
    chk("mid_left",    64'(q.size()), 64'd6);
    q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
